vga_write_arbiter: RTL and testbench
====================================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_REQ, 4, number of drawing requesters.
- nX, 10, X coordinate width.
- nY, 9, Y coordinate width.
- COLOR_DEPTH, 9, pixel color width.
- PRIO_IDX, 0, index of the priority requester (player object).
- MAX_HOLD, 4096, maximum grant length in cycles.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clock, in, 1, system clock.
- Resetn, in, 1, synchronous active-low reset.
- req, in, NUM_REQ, per-requester burst request, held for the whole burst.
- prio_boost, in, 1, priority requester wins the next arbitration (collision mode).
- in_x, in, NUM_REQ*nX, packed requester X; slice i belongs to requester i.
- in_y, in, NUM_REQ*nY, packed requester Y.
- in_color, in, NUM_REQ*COLOR_DEPTH, packed requester color.
- in_write, in, NUM_REQ, requester pixel write strobes.
- grant, out, NUM_REQ, one-hot ownership of the VGA port.
- VGA_x, out, nX, muxed X to the VGA adapter.
- VGA_y, out, nY, muxed Y to the VGA adapter.
- VGA_color, out, COLOR_DEPTH, muxed color.
- VGA_write, out, 1, muxed write strobe.
- busy, out, 1, some requester holds the grant.
- overrun, out, 1, sticky flag: a grant was revoked by timeout.
- dropped_write, out, 1, sticky flag: an in_write was asserted without a grant.

Function
REQ-003 FSM states: IDLE, OWN, GAP.
REQ-004 IDLE: if any req bit is set, select an owner, set grant to one-hot(owner), go to OWN; grant is visible the cycle after req is sampled.
REQ-005 Selection:
- If prio_boost=1 and req[PRIO_IDX]=1, the owner is PRIO_IDX.
- Otherwise round-robin: the first requesting index after last_owner, wrapping from NUM_REQ-1 to 0.
REQ-006 last_owner updates on every grant; its reset value is NUM_REQ-1, so requester 0 is checked first after reset.
REQ-007 OWN: hold_cnt increments each cycle. Leave for GAP when either holds:
- req[owner]=0, or
- hold_cnt = MAX_HOLD-1 (timeout; set overrun).
REQ-008 No preemption in OWN: prio_boost and other requests are ignored until OWN exits.
REQ-009 GAP: one cycle with grant=0 and VGA_write=0, then IDLE; this guarantees one dead cycle between owners.
REQ-010 Output registers: VGA_x/y/color/write = owner's in_x/y/color/write slice registered one cycle. VGA_write is forced to 0 whenever grant is 0 in that cycle.
REQ-011 In IDLE and GAP, VGA_x, VGA_y and VGA_color hold their last values.
REQ-012 in_write[i]=1 while grant[i]=0 is discarded and sets dropped_write.
REQ-013 busy = (state == OWN).
REQ-014 hold_cnt is $clog2(MAX_HOLD) bits wide and clears on entry to OWN.
REQ-015 If req[owner] falls in the same cycle as the timeout, this is a normal release: go to GAP without setting overrun.
REQ-016 A requester that drops req and re-raises it during GAP competes normally in the next IDLE; it gets no priority for having just finished.

Reset
REQ-017 When Resetn=0 at a Clock edge, the following are set in that same edge:
- state=IDLE, grant=0, last_owner=NUM_REQ-1, hold_cnt=0.
- VGA_x, VGA_y, VGA_color, VGA_write = 0.
- overrun=0, dropped_write=0.
REQ-018 Reset mid-burst revokes the grant immediately; no partial state survives.

Structure
REQ-019 The state encoding, the default MAX_HOLD and the packed-bus slice widths belong in the shared lane_runner_pkg.
REQ-020 The round-robin/priority selector is a separate combinational sub-module, rr_priority_select, with inputs (req, last_owner, prio_boost) and output the one-hot owner.

Verification
REQ-021 Directed scenarios:
- Single requester: req=4'b0010 held 3600 cycles. Required: grant=4'b0010 one cycle later; 3600 writes forwarded with one-cycle latency; then one GAP cycle.
- Round-robin order: req=4'b1111 after reset, each burst 10 cycles. Required grant order 0,1,2,3,0.
- Priority boost: last_owner=0, req=4'b0111, prio_boost=1. Required: next grant=4'b0001, not 4'b0010.
- Timeout: MAX_HOLD=16, req[2] held continuously. Required: grant drops after 16 cycles; overrun=1; GAP; req[2] may be regranted.
- Dropped write: grant to 1, in_write[3]=1. Required: dropped_write=1 and VGA_write follows in_write[1] only.
- Reset mid-OWN: Resetn=0 at hold_cnt=100. Required: next cycle grant=0, VGA_write=0, overrun=0.

Source files
------------

// File: rtl/lane_runner_pkg.sv
// Shared types and defaults for the VGA write arbiter slice: FSM state
// encoding, default packed-bus lane widths and small index helpers.
package lane_runner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_NX          = 10;
    localparam int DEF_NY          = 9;
    localparam int DEF_COLOR_DEPTH = 9;
    localparam int DEF_MAX_HOLD    = 4096;

    // Width needed to hold an index/count below n; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of the (single) set bit of a one-hot vector; 0 when empty.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Requester-side and VGA-side bus of the write arbiter. The requesters (and
// whoever watches the VGA port) are the master; the arbiter is the slave.
interface vga_write_arbiter_if #(
    parameter int NUM_REQ     = lane_runner_pkg::DEF_NUM_REQ,
    parameter int nX          = lane_runner_pkg::DEF_NX,
    parameter int nY          = lane_runner_pkg::DEF_NY,
    parameter int COLOR_DEPTH = lane_runner_pkg::DEF_COLOR_DEPTH
);
    logic [NUM_REQ-1:0]             req;
    logic                           prio_boost;
    logic [NUM_REQ*nX-1:0]          in_x;
    logic [NUM_REQ*nY-1:0]          in_y;
    logic [NUM_REQ*COLOR_DEPTH-1:0] in_color;
    logic [NUM_REQ-1:0]             in_write;

    logic [NUM_REQ-1:0]             grant;
    logic [nX-1:0]                  VGA_x;
    logic [nY-1:0]                  VGA_y;
    logic [COLOR_DEPTH-1:0]         VGA_color;
    logic                           VGA_write;
    logic                           busy;
    logic                           overrun;
    logic                           dropped_write;

    modport master (
        output req, prio_boost, in_x, in_y, in_color, in_write,
        input  grant, VGA_x, VGA_y, VGA_color, VGA_write, busy, overrun, dropped_write
    );

    modport slave (
        input  req, prio_boost, in_x, in_y, in_color, in_write,
        output grant, VGA_x, VGA_y, VGA_color, VGA_write, busy, overrun, dropped_write
    );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational owner selector: the priority requester wins outright when
// boosted, otherwise the first requester after last_owner (wrapping) wins.
module rr_priority_select
    import lane_runner_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int PRIO_IDX = 0,
    parameter int IDXW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last_owner,
    input  logic               prio_boost,
    output logic [NUM_REQ-1:0] owner_oh
);

    int   idx;
    logic found;

    // Scan from last_owner+1 around to last_owner itself; first hit wins.
    always_comb begin
        owner_oh = '0;
        found    = 1'b0;
        idx      = 0;
        if (prio_boost && req[PRIO_IDX]) begin
            owner_oh[PRIO_IDX] = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_owner) + k) % NUM_REQ;
                if (!found && req[idx]) begin
                    owner_oh[idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates several drawing engines onto one VGA pixel-write port. A
// requester owns the port for a whole burst (no preemption), bursts are
// capped at MAX_HOLD cycles, and one dead cycle separates owners.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | port free; pick an owner as soon as any req is seen
// ST_OWN  | grant held by last_owner until it drops req or times out
// ST_GAP  | single dead cycle: no grant, no write, then back to IDLE
module vga_write_arbiter
    import lane_runner_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int nX          = DEF_NX,
    parameter int nY          = DEF_NY,
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int PRIO_IDX    = 0,
    parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
    input logic                Clock,
    input logic                Resetn,
    vga_write_arbiter_if.slave bus
);

    localparam int IDXW   = idx_width(NUM_REQ);
    localparam int HOLD_W = idx_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0]   RESET_OWNER = IDXW'(NUM_REQ - 1);

    arb_state_t             state;
    logic [NUM_REQ-1:0]     grant_q;
    logic [IDXW-1:0]        last_owner;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   busy_q;
    logic                   overrun_q;
    logic                   dropped_q;
    logic [nX-1:0]          vga_x_q;
    logic [nY-1:0]          vga_y_q;
    logic [COLOR_DEPTH-1:0] vga_color_q;
    logic                   vga_write_q;

    logic [NUM_REQ-1:0]     sel_oh;
    logic [IDXW-1:0]        sel_idx;
    logic [nX-1:0]          own_x;
    logic [nY-1:0]          own_y;
    logic [COLOR_DEPTH-1:0] own_color;
    logic                   own_write;
    logic                   own_req;

    rr_priority_select #(
        .NUM_REQ  (NUM_REQ),
        .PRIO_IDX (PRIO_IDX)
    ) u_select (
        .req        (bus.req),
        .last_owner (last_owner),
        .prio_boost (bus.prio_boost),
        .owner_oh   (sel_oh)
    );

    assign sel_idx = IDXW'(onehot_to_idx(32'(sel_oh)));

    // last_owner doubles as the current owner index while in ST_OWN.
    always_comb begin
        own_x     = bus.in_x[int'(last_owner)*nX +: nX];
        own_y     = bus.in_y[int'(last_owner)*nY +: nY];
        own_color = bus.in_color[int'(last_owner)*COLOR_DEPTH +: COLOR_DEPTH];
        own_write = bus.in_write[last_owner];
        own_req   = bus.req[last_owner];
    end

    // Arbitration FSM, hold timer, registered VGA mux and sticky error flags.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            last_owner  <= RESET_OWNER;
            hold_cnt    <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            dropped_q   <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_write_q <= 1'b0;
        end else begin
            if ((bus.in_write & ~grant_q) != '0) begin
                dropped_q <= 1'b1;
            end

            // Only the owner's lane reaches the port; coordinates hold otherwise.
            if (grant_q != '0) begin
                vga_x_q     <= own_x;
                vga_y_q     <= own_y;
                vga_color_q <= own_color;
                vga_write_q <= own_write;
            end else begin
                vga_write_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.req != '0) begin
                        grant_q    <= sel_oh;
                        last_owner <= sel_idx;
                        hold_cnt   <= '0;
                        busy_q     <= 1'b1;
                        state      <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // A release on the timeout cycle is a normal release.
                    if (!own_req) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state   <= ST_GAP;
                    end else if (hold_cnt == HOLD_LAST) begin
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        overrun_q <= 1'b1;
                        state     <= ST_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.VGA_x         = vga_x_q;
    assign bus.VGA_y         = vga_y_q;
    assign bus.VGA_color     = vga_color_q;
    assign bus.VGA_write     = vga_write_q;
    assign bus.busy          = busy_q;
    assign bus.overrun       = overrun_q;
    assign bus.dropped_write = dropped_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: a driver applies stimulus on the falling edge,
// steps a burst-level reference model and queues the expected port state; a
// monitor pops and compares after every rising edge. Directed scenarios add
// explicit checks on top of the scoreboard.
module tb_vga_write_arbiter;

    localparam int NR   = 4;
    localparam int NX   = 10;
    localparam int NY   = 9;
    localparam int CD   = 9;
    localparam int PRIO = 0;
    localparam int MAXH = 4096;

    typedef struct {
        logic [NR-1:0] grant;
        logic [NX-1:0] vx;
        logic [NY-1:0] vy;
        logic [CD-1:0] vc;
        logic          vw;
        logic          busy;
        logic          over;
        logic          drop;
    } exp_t;

    exp_t exp_q[$];

    logic Clock = 1'b0;
    logic Resetn;
    always #5 Clock = ~Clock;

    vga_write_arbiter_if #(.NUM_REQ(NR), .nX(NX), .nY(NY), .COLOR_DEPTH(CD)) bus();

    vga_write_arbiter #(
        .NUM_REQ(NR), .nX(NX), .nY(NY), .COLOR_DEPTH(CD),
        .PRIO_IDX(PRIO), .MAX_HOLD(MAXH)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int grant_log[$];
    logic [NR-1:0] prev_grant = '0;

    // stimulus
    logic          rstn;
    logic [NR-1:0] r_req, r_w;
    logic          r_boost;
    logic [NX-1:0] r_x[NR];
    logic [NY-1:0] r_y[NR];
    logic [CD-1:0] r_c[NR];

    // reference model: owner index (-1 = port free), burst length so far
    int            m_owner, m_last, m_held;
    bit            m_gap, m_vw, m_over, m_drop;
    logic [NX-1:0] m_vx;
    logic [NY-1:0] m_vy;
    logic [CD-1:0] m_vc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step();
        logic [NR-1:0] cur;
        int o;
        if (!rstn) begin
            m_owner = -1; m_gap = 0; m_last = NR - 1; m_held = 0;
            m_vx = '0; m_vy = '0; m_vc = '0; m_vw = 0; m_over = 0; m_drop = 0;
            return;
        end
        cur = model_grant();
        if ((r_w & ~cur) != '0) m_drop = 1;
        if (m_owner >= 0) begin
            m_vx = r_x[m_owner]; m_vy = r_y[m_owner]; m_vc = r_c[m_owner];
            m_vw = r_w[m_owner];
        end else begin
            m_vw = 0;
        end
        if (m_owner >= 0) begin
            if (!r_req[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else if (m_held == MAXH) begin
                m_owner = -1; m_gap = 1; m_over = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (r_req != '0) begin
            o = -1;
            if (r_boost && r_req[PRIO]) o = PRIO;
            else begin
                for (int k = 1; k <= NR; k++) begin
                    int j;
                    j = (m_last + k) % NR;
                    if (o < 0 && r_req[j]) o = j;
                end
            end
            m_owner = o; m_last = o; m_held = 1;
        end
    endtask

    task automatic drive_cycle();
        exp_t e;
        @(negedge Clock);
        Resetn = rstn;
        bus.req = r_req;
        bus.prio_boost = r_boost;
        bus.in_write = r_w;
        for (int i = 0; i < NR; i++) begin
            bus.in_x[i*NX +: NX]     = r_x[i];
            bus.in_y[i*NY +: NY]     = r_y[i];
            bus.in_color[i*CD +: CD] = r_c[i];
        end
        model_step();
        e.grant = model_grant();
        e.vx = m_vx; e.vy = m_vy; e.vc = m_vc; e.vw = m_vw;
        e.busy = (m_owner >= 0); e.over = m_over; e.drop = m_drop;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge Clock);
        #2;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) begin
            r_x[i] = NX'($urandom_range(0, (1 << NX) - 1));
            r_y[i] = NY'($urandom_range(0, (1 << NY) - 1));
            r_c[i] = CD'($urandom_range(0, (1 << CD) - 1));
        end
    endtask

    task automatic reset_pulse();
        rstn = 0;
        drive_cycle();
        rstn = 1;
    endtask

    task automatic drain();
        r_req = '0; r_w = '0; r_boost = 0;
        for (int n = 0; n < 10 && !(m_owner < 0 && !m_gap); n++) drive_cycle();
        drive_cycle();
    endtask

    // Monitor: compare the port against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.grant, bus.VGA_x, bus.VGA_y, bus.VGA_color, bus.VGA_write} !==
                    {e.grant, e.vx, e.vy, e.vc, e.vw}) begin
                    errors++;
                    $display("FAIL sb_port @%0t: got g=%b x=%0h y=%0h c=%0h w=%b expected g=%b x=%0h y=%0h c=%0h w=%b",
                             $time, bus.grant, bus.VGA_x, bus.VGA_y, bus.VGA_color, bus.VGA_write,
                             e.grant, e.vx, e.vy, e.vc, e.vw);
                end
                checks++;
                if ({bus.busy, bus.overrun, bus.dropped_write} !== {e.busy, e.over, e.drop}) begin
                    errors++;
                    $display("FAIL sb_flags @%0t: got busy/ovr/drop=%b%b%b expected %b%b%b",
                             $time, bus.busy, bus.overrun, bus.dropped_write, e.busy, e.over, e.drop);
                end
            end
            if (bus.VGA_write === 1'b1) wr_cnt++;
            if (bus.grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < NR; i++) if (bus.grant[i]) grant_log.push_back(i);
            end
            prev_grant = bus.grant;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int own_len;
        bit seen;
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};

        Resetn = 0;
        bus.req = '0; bus.prio_boost = 0; bus.in_write = '0;
        bus.in_x = '0; bus.in_y = '0; bus.in_color = '0;
        rstn = 0; r_req = '0; r_w = '0; r_boost = 0;
        for (int i = 0; i < NR; i++) begin r_x[i] = '0; r_y[i] = '0; r_c[i] = '0; end
        model_step();

        // reset state
        repeat (2) drive_cycle();
        settle();
        check("reset_grant", 32'(bus.grant), 32'(0));
        check("reset_flags", 32'({bus.busy, bus.overrun, bus.dropped_write, bus.VGA_write}), 32'(0));
        rstn = 1;

        // single requester, 3600-write burst
        r_req = 4'b0010;
        drive_cycle(); settle();
        check("single_grant", 32'(bus.grant), 32'(4'b0010));
        wr_cnt = 0;
        r_w = 4'b0010;
        repeat (3600) begin rand_data(); drive_cycle(); end
        r_req = '0; r_w = '0;
        drive_cycle(); settle();
        check("single_release", 32'(bus.grant), 32'(0));
        check("single_writes", 32'(wr_cnt), 32'(3600));
        check("single_no_drop", 32'(bus.dropped_write), 32'(0));
        drain();

        // round-robin order with 10-cycle bursts
        reset_pulse();
        settle();
        grant_log.delete();
        r_req = 4'b1111;
        for (int n = 0; n < 100 && grant_log.size() < 5; n++) begin
            for (int i = 0; i < NR; i++) r_req[i] = !(m_owner == i && m_held >= 10);
            drive_cycle();
        end
        check("rr_count", 32'(grant_log.size() >= 5), 32'(1));
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check($sformatf("rr_order_%0d", i), 32'(grant_log[i]), 32'(rr_exp[i]));
        drain();

        // priority boost with last_owner = 0
        reset_pulse();
        r_req = 4'b0001;
        repeat (3) drive_cycle();
        drain();
        r_req = 4'b0111; r_boost = 1;
        drive_cycle(); settle();
        check("prio_boost", 32'(bus.grant), 32'(4'b0001));
        r_boost = 0; r_req = 4'b0110;
        repeat (3) drive_cycle();
        settle();
        check("rr_after_prio", 32'(bus.grant), 32'(4'b0010));
        r_req = 4'b0111; r_boost = 1;
        repeat (3) drive_cycle();
        settle();
        check("no_preempt", 32'(bus.grant), 32'(4'b0010));
        drain();

        // timeout on a continuously held request
        r_req = 4'b0100;
        drive_cycle(); settle();
        check("timeout_grant", 32'(bus.grant), 32'(4'b0100));
        own_len = 1;
        for (int n = 0; n < MAXH + 50; n++) begin
            drive_cycle(); settle();
            if (bus.grant == 4'b0100) own_len++;
            else break;
        end
        check("timeout_len", 32'(own_len), 32'(MAXH));
        check("timeout_overrun", 32'(bus.overrun), 32'(1));
        drive_cycle(); settle();
        check("timeout_gap", 32'(bus.grant), 32'(0));
        drive_cycle(); settle();
        check("timeout_regrant", 32'(bus.grant), 32'(4'b0100));

        // reset in the middle of a burst (hold_cnt = 100)
        repeat (100) drive_cycle();
        rstn = 0;
        drive_cycle(); settle();
        check("rst_mid_grant", 32'(bus.grant), 32'(0));
        check("rst_mid_write", 32'(bus.VGA_write), 32'(0));
        check("rst_mid_overrun", 32'(bus.overrun), 32'(0));
        rstn = 1;
        drain();

        // release on the timeout cycle is not an overrun
        r_req = 4'b1000;
        seen = 0;
        for (int n = 0; n < MAXH + 50; n++) begin
            r_req[3] = !(m_owner == 3 && m_held == MAXH);
            drive_cycle();
            if (m_owner == 3) seen = 1;
            if (seen && m_owner < 0) break;
        end
        settle();
        check("late_release_overrun", 32'(bus.overrun), 32'(0));
        drain();

        // write from a non-owner is dropped
        check("drop_before", 32'(bus.dropped_write), 32'(0));
        r_req = 4'b0010;
        drive_cycle(); settle();
        r_w = 4'b1010; rand_data();
        drive_cycle(); settle();
        check("drop_flag", 32'(bus.dropped_write), 32'(1));
        check("drop_owner_write", 32'(bus.VGA_write), 32'(1));
        check("drop_owner_x", 32'(bus.VGA_x), 32'(r_x[1]));
        r_w = 4'b1000;
        drive_cycle(); settle();
        check("drop_masked_write", 32'(bus.VGA_write), 32'(0));
        drain();

        // randomized traffic
        reset_pulse();
        r_req = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 7) == 0) r_req[i] = ~r_req[i];
            r_boost = ($urandom_range(0, 3) == 0);
            r_w = NR'($urandom);
            rand_data();
            rstn = ($urandom_range(0, 599) != 0);
            drive_cycle();
        end
        rstn = 1;
        drain();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
